// File: rtl/rr_ring_arb.sv
// -----------------------------------------------------------------------------
// rr_ring_arb
//
// Purpose:
//   Round-robin arbiter that shares one downstream resource among N
//   requesters. The priority pointer is a one-hot ring that moves to the
//   position just past each new winner. A grant is owned until the owner
//   drops its request. Only then is the resource re-arbitrated, in the same
//   cycle, so a hand-over costs no dead cycle.
//
// Optional feature (macro RR_HOLD_TIMEOUT_EN):
//   When defined, a hold counter bounds each grant to MAX_HOLD cycles. The
//   grant is revoked after that many cycles and tmo pulses for one cycle.
//   When undefined, grants are unbounded, MAX_HOLD is ignored and tmo is 0.
//
// Parameters:
//   N         number of requesters (N >= 2)
//   MAX_HOLD  maximum grant length in cycles (timeout build only)
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous reset, active-high
//   req        in   [N-1:0] level request per requester, held while owning
//   gnt        out  [N-1:0] registered one-hot grant, all-zero when idle
//   gnt_id     out  [$clog2(N)-1:0] binary index of the granted requester
//   busy       out  high while any grant is active (|gnt)
//   tmo        out  one-cycle pulse when a grant was revoked by hold timeout
//   dbg_state  out  FSM state for observation (0 = IDLE, 1 = GRANT)
//
// Handshake:
//   A requester raises req[i] and keeps it high. The resource belongs to it
//   from the first cycle that gnt[i] is high until the cycle after it drops
//   req[i]. Other requests are not looked at while the resource is owned.
// -----------------------------------------------------------------------------
module rr_ring_arb #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 busy,
    output logic                 tmo,
    output logic                 dbg_state
);

    localparam int IDW = $clog2(N);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [N-1:0]   r_gnt;
    logic [N-1:0]   w_gnt_nxt;
    logic [IDW-1:0] r_gnt_id;
    logic [IDW-1:0] w_gnt_id_nxt;
    logic [N-1:0]   r_ptr;
    logic [N-1:0]   w_ptr_nxt;

    logic           w_owner_req;
    logic           w_timeout_hit;
    logic           w_release;
    logic           w_new_grant;

    logic [N-1:0]   w_cand;
    logic [N-1:0]   w_below;
    logic [N-1:0]   w_cand_hi;
    logic [N-1:0]   w_pick_src;
    logic [N-1:0]   w_win_oh;
    logic [N-1:0]   w_ptr_rot;
    logic [IDW-1:0] w_win;
    logic           w_found;

    // -------------------------------------------------------------------------
    // Winner selection
    // -------------------------------------------------------------------------

    // r_gnt is zero in IDLE, so this is simply req there. In GRANT it drops
    // the current owner, which keeps a timed-out owner from re-winning in
    // the cycle it is evicted.
    assign w_cand = req & ~r_gnt;

    // The owner still wants the resource.
    assign w_owner_req = |(req & r_gnt);

    // Bits strictly below the one-hot pointer. Candidates at or above the
    // pointer take precedence. If there are none, the search wraps to bit 0.
    assign w_below    = r_ptr - {{(N-1){1'b0}}, 1'b1};
    assign w_cand_hi  = w_cand & ~w_below;
    assign w_pick_src = (|w_cand_hi) ? w_cand_hi : w_cand;

    // Isolate the lowest set bit (x & -x) to get the winner as one-hot.
    assign w_win_oh = w_pick_src & (~w_pick_src + {{(N-1){1'b0}}, 1'b1});
    assign w_found  = |w_cand;

    // Pointer for the next round: one position past the winner, wrapping.
    assign w_ptr_rot = {w_win_oh[N-2:0], w_win_oh[N-1]};

    always_comb begin
        w_win = '0;
        for (int i = 0; i < N; i++) begin
            if (w_win_oh[i]) begin
                w_win = IDW'(i);
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_gnt    <= '0;
            r_gnt_id <= '0;
            r_ptr    <= {{(N-1){1'b0}}, 1'b1};
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_gnt_id <= w_gnt_id_nxt;
            r_ptr    <= w_ptr_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and next outputs
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_gnt_id_nxt = r_gnt_id;
        w_ptr_nxt    = r_ptr;
        w_new_grant  = 1'b0;
        w_release    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt  = S_GRANT;
                    w_gnt_nxt    = w_win_oh;
                    w_gnt_id_nxt = w_win;
                    w_ptr_nxt    = w_ptr_rot;
                    w_new_grant  = 1'b1;
                end
            end

            S_GRANT: begin
                // A timeout is treated the same as a voluntary release.
                w_release = !w_owner_req || w_timeout_hit;
                if (w_release) begin
                    if (w_found) begin
                        w_state_nxt  = S_GRANT;
                        w_gnt_nxt    = w_win_oh;
                        w_gnt_id_nxt = w_win;
                        w_ptr_nxt    = w_ptr_rot;
                        w_new_grant  = 1'b1;
                    end else begin
                        w_state_nxt  = S_IDLE;
                        w_gnt_nxt    = '0;
                        w_gnt_id_nxt = '0;
                    end
                end
            end

            default: begin
                w_state_nxt  = S_IDLE;
                w_gnt_nxt    = '0;
                w_gnt_id_nxt = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Optional hold timeout
    // -------------------------------------------------------------------------
`ifdef RR_HOLD_TIMEOUT_EN
    localparam int HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    logic [HCW-1:0] r_hold_cnt;
    logic           r_tmo;

    // The counter holds the number of cycles already spent in the current
    // grant. At MAX_HOLD-1 the current cycle is the last one allowed.
    assign w_timeout_hit = (r_state == S_GRANT) && w_owner_req &&
                           (r_hold_cnt == HCW'(MAX_HOLD - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_cnt <= '0;
            r_tmo      <= 1'b0;
        end else begin
            if (w_new_grant) begin
                r_hold_cnt <= '0;
            end else if (r_state == S_GRANT) begin
                r_hold_cnt <= r_hold_cnt + HCW'(1);
            end
            // Goes high in the first cycle without the revoked grant.
            r_tmo <= w_timeout_hit;
        end
    end

    assign tmo = r_tmo;
`else
    logic w_unused_hold;

    assign w_timeout_hit = 1'b0;
    assign tmo           = 1'b0;
    assign w_unused_hold = (MAX_HOLD > 0) & w_new_grant & w_release;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign busy      = |r_gnt;
    assign dbg_state = (r_state == S_GRANT);

endmodule

// File: tb/tb_rr_ring_arb.sv
// -----------------------------------------------------------------------------
// tb_rr_ring_arb
//
// Self-checking bench for rr_ring_arb with N=4 and MAX_HOLD=4. Each table row
// drives one cycle of {rst, req}. The row also holds the grant and tmo
// expected right after that clock edge. gnt_id, busy and the debug state are
// derived from the expected grant. Compile with +define+RR_HOLD_TIMEOUT_EN
// to run the timeout rows instead of the unbounded-hold rows.
// -----------------------------------------------------------------------------
module tb_rr_ring_arb;

    localparam int N        = 4;
    localparam int IDW      = 2;
    localparam int MAX_HOLD = 4;
    localparam int W        = N + IDW + 3;

    // -------------------------------------------------------------------------
    // Clock / reset / DUT
    // -------------------------------------------------------------------------
    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           busy;
    logic           tmo;
    logic           dbg_state;

    always #5 clk = ~clk;

    rr_ring_arb #(
        .N        (N),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .busy      (busy),
        .tmo       (tmo),
        .dbg_state (dbg_state)
    );

    // -------------------------------------------------------------------------
    // Vector table and scoreboard
    // -------------------------------------------------------------------------
    typedef struct {
        logic         rst;
        logic [N-1:0] req;
        logic [N-1:0] gnt;
        logic         tmo;
        string        tag;
    } vec_t;

    vec_t           vecs[$];
    logic [W-1:0]   exp_q[$];
    int             n_cmp = 0;
    int             n_err = 0;

    function automatic logic [IDW-1:0] enc(input logic [N-1:0] v);
        logic [IDW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) r = IDW'(i);
        end
        return r;
    endfunction

    task automatic add(input logic r, input logic [N-1:0] q,
                       input logic [N-1:0] g, input logic t, input string tag);
        vec_t v;
        v.rst = r;
        v.req = q;
        v.gnt = g;
        v.tmo = t;
        v.tag = tag;
        vecs.push_back(v);
    endtask

    // Called just after a falling edge. Drives one cycle of inputs, then
    // compares the outputs at the next falling edge.
    task automatic apply(input logic r, input logic [N-1:0] q,
                         input logic [N-1:0] eg, input logic et,
                         input string tag);
        logic [W-1:0] got;
        logic [W-1:0] exp;
        rst = r;
        req = q;
        exp_q.push_back({eg, enc(eg), |eg, et, |eg});
        @(posedge clk);
        @(negedge clk);
        got = {gnt, gnt_id, busy, tmo, dbg_state};
        exp = exp_q.pop_front();
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got gnt=%b id=%0d busy=%b tmo=%b st=%b, expected gnt=%b id=%0d busy=%b tmo=%b st=%b",
                     tag, got[W-1 -: N], got[IDW+2:3], got[2], got[1], got[0],
                     exp[W-1 -: N], exp[IDW+2:3], exp[2], exp[1], exp[0]);
        end
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        rst = 1'b1;
        req = '0;

        // Reset: requests are ignored while reset is held.
        add(1, 4'b1111, 4'b0000, 0, "rst_hold0");
        add(1, 4'b1111, 4'b0000, 0, "rst_hold1");
        add(0, 4'b1111, 4'b0001, 0, "rst_release");

        // Rotation: 0 -> 1 -> 2 -> 3 -> 0 with no gap between grants.
        add(0, 4'b1111, 4'b0001, 0, "rot_hold0a");
        add(0, 4'b1111, 4'b0001, 0, "rot_hold0b");
        add(0, 4'b1110, 4'b0010, 0, "rot_to1");
        add(0, 4'b1111, 4'b0010, 0, "rot_hold1a");
        add(0, 4'b1111, 4'b0010, 0, "rot_hold1b");
        add(0, 4'b1101, 4'b0100, 0, "rot_to2");
        add(0, 4'b1111, 4'b0100, 0, "rot_hold2a");
        add(0, 4'b1111, 4'b0100, 0, "rot_hold2b");
        add(0, 4'b1011, 4'b1000, 0, "rot_to3");
        add(0, 4'b1111, 4'b1000, 0, "rot_hold3a");
        add(0, 4'b1111, 4'b1000, 0, "rot_hold3b");
        add(0, 4'b0111, 4'b0001, 0, "rot_wrap0");
        add(0, 4'b0000, 4'b0000, 0, "idle_a");
        add(0, 4'b0000, 4'b0000, 0, "idle_b");

        // Hold/ignore: other requests wait until owner 2 releases.
        add(0, 4'b0100, 4'b0100, 0, "hold_g2");
        add(0, 4'b1101, 4'b0100, 0, "hold_ign_a");
        add(0, 4'b1101, 4'b0100, 0, "hold_ign_b");
        add(0, 4'b1001, 4'b1000, 0, "hold_next3");
        add(0, 4'b1001, 4'b1000, 0, "hold_keep3");
        add(0, 4'b0000, 4'b0000, 0, "hold_idle");

        // Wrap/skip: set the pointer to 3, then only req[1] is present.
        add(0, 4'b0100, 4'b0100, 0, "wrap_g2");
        add(0, 4'b0000, 4'b0000, 0, "wrap_idle");
        add(0, 4'b0010, 4'b0010, 0, "wrap_g1");
        add(0, 4'b0000, 4'b0000, 0, "wrap_idle2");
        add(0, 4'b1010, 4'b1000, 0, "wrap_ptr2");
        add(0, 4'b0000, 4'b0000, 0, "wrap_idle3");

        // Reset during a grant: the pointer returns to bit 0.
        add(0, 4'b0100, 4'b0100, 0, "mid_g2");
        add(0, 4'b0100, 4'b0100, 0, "mid_hold2");
        add(1, 4'b0101, 4'b0000, 0, "mid_rst");
        add(0, 4'b0101, 4'b0001, 0, "mid_g0");
        add(0, 4'b0101, 4'b0001, 0, "mid_hold0");
        add(0, 4'b0100, 4'b0100, 0, "mid_g2b");
        add(0, 4'b0000, 4'b0000, 0, "mid_idle");

`ifdef RR_HOLD_TIMEOUT_EN
        // Two requesters alternate as each grant times out.
        add(0, 4'b0011, 4'b0001, 0, "tmo_g0");
        for (int i = 0; i < 3; i++) add(0, 4'b0011, 4'b0001, 0, "tmo_hold0");
        add(0, 4'b0011, 4'b0010, 1, "tmo_to1");
        for (int i = 0; i < 3; i++) add(0, 4'b0011, 4'b0010, 0, "tmo_hold1");
        add(0, 4'b0011, 4'b0001, 1, "tmo_to0");
        add(0, 4'b0000, 4'b0000, 0, "tmo_idle");
        // A single requester gets one idle cycle, then the grant again.
        add(0, 4'b0100, 4'b0100, 0, "tmo1_g2");
        for (int i = 0; i < 3; i++) add(0, 4'b0100, 4'b0100, 0, "tmo1_hold2");
        add(0, 4'b0100, 4'b0000, 1, "tmo1_gap");
        add(0, 4'b0100, 4'b0100, 0, "tmo1_regrant");
        add(0, 4'b0000, 4'b0000, 0, "tmo1_idle");
`else
        // With no timeout, the grant is held for as long as req[owner] stays set.
        add(0, 4'b0011, 4'b0001, 0, "long_g0");
        for (int i = 0; i < 20; i++) add(0, 4'b0011, 4'b0001, 0, "long_hold0");
        add(0, 4'b0000, 4'b0000, 0, "long_idle");
`endif

        @(negedge clk);
        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].req, vecs[i].gnt, vecs[i].tmo, vecs[i].tag);
        end

        // A lone requester is granted the next cycle, whatever the pointer is.
        // It keeps the grant for 1..3 cycles, then the arbiter goes idle.
        for (int k = 0; k < 8; k++) begin
            int unsigned who;
            int unsigned hold;
            logic [N-1:0] oh;
            who  = $urandom_range(0, N - 1);
            hold = $urandom_range(1, 3);
            oh   = '0;
            oh[who] = 1'b1;
            apply(0, oh, oh, 0, "solo_grant");
            for (int h = 1; h < int'(hold); h++) apply(0, oh, oh, 0, "solo_hold");
            apply(0, 4'b0000, 4'b0000, 0, "solo_idle");
        end

        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Every step runs for a fixed number of cycles. This only fires if the
    // clock or a task stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
